// File: rtl/des_iter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// des_iter_ctrl_pkg
//   Shared constants for the iterative DES control slice.
//   - N_R      : number of DES rounds
//   - state_t  : FSM state encoding (3-bit)
//   - ROT_ENC / ROT_DEC : per-round key-half rotation amounts, packed 2 bits
//     per round with round 0 in bits [1:0].
// -----------------------------------------------------------------------------
package des_iter_ctrl_pkg;

    localparam int N_R = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_DONE  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    // Encrypt (left):  1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
    localparam logic [31:0] ROT_ENC = 32'h6AA9_AAA5;
    // Decrypt (right): 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1
    // Round 0 does not move: the pre-processed key already sits at the
    // position the last encrypt round left it in.
    localparam logic [31:0] ROT_DEC = 32'h6AA9_AAA4;

endpackage

// File: rtl/des_rot_lut.sv
// -----------------------------------------------------------------------------
// des_rot_lut
//   Combinational round-index -> key rotation amount lookup.
//   Optional feature macro: DES_DECRYPT_EN (adds dir input and decrypt table).
// Ports:
//   idx  in  4  round index (0..15)
//   dir  in  1  0=encrypt table, 1=decrypt table (DES_DECRYPT_EN only)
//   rot  out 2  rotation amount for this round
// -----------------------------------------------------------------------------
module des_rot_lut
    import des_iter_ctrl_pkg::*;
(
    input  logic [3:0] idx,
`ifdef DES_DECRYPT_EN
    input  logic       dir,
`endif
    output logic [1:0] rot
);

`ifdef DES_DECRYPT_EN
    logic [31:0] tab;
    assign tab = dir ? ROT_DEC : ROT_ENC;
    assign rot = tab[{idx, 1'b0} +: 2];
`else
    assign rot = ROT_ENC[{idx, 1'b0} +: 2];
`endif

endmodule

// File: rtl/des_iter_ctrl.sv
// -----------------------------------------------------------------------------
// des_iter_ctrl
//   Sequencer for the iterative DES datapath. Takes a 4-phase req/ack request,
//   strobes ld, runs the shared round stage for NR cycles (en, rnd, rot,
//   rot_dir), strobes fin, then holds ack until req drops.
//   Optional feature macro: DES_DECRYPT_EN (dec port, latched direction).
// Ports:
//   clk      in   1   clock
//   rst      in   1   asynchronous active-low reset
//   req      in   1   request
//   ack      out  1   acknowledge (result valid)
//   dec      in   1   1=decrypt (DES_DECRYPT_EN only)
//   ld       out  1   load datapath state registers
//   en       out  1   round enable
//   rnd      out  RW  round index
//   rot      out  2   key rotation amount (0 outside ROUND)
//   rot_dir  out  1   0=left (encrypt), 1=right (decrypt)
//   fin      out  1   capture output register
//   busy     out  1   not IDLE
// -----------------------------------------------------------------------------
module des_iter_ctrl
    import des_iter_ctrl_pkg::*;
#(
    parameter int NR = N_R,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    output logic          ack,
`ifdef DES_DECRYPT_EN
    input  logic          dec,
`endif
    output logic          ld,
    output logic          en,
    output logic [RW-1:0] rnd,
    output logic [1:0]    rot,
    output logic          rot_dir,
    output logic          fin,
    output logic          busy
);

    state_t     state, state_nx;
    logic       last;
    logic       dir;
    logic [1:0] lut_rot;

    assign last = (rnd == RW'(NR - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; req drops during LOAD/ROUND/DONE are ignored
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req)  state_nx = S_LOAD;
            S_LOAD:            state_nx = S_ROUND;
            S_ROUND: if (last) state_nx = S_DONE;
            S_DONE:            state_nx = S_ACK;
            S_ACK:   if (!req) state_nx = S_IDLE;
            default:           state_nx = S_IDLE;
        endcase
    end

    // Round counter: cleared at LOAD, saturates at NR-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           rnd <= '0;
        else if (state == S_LOAD)           rnd <= '0;
        else if (state == S_ROUND && !last) rnd <= rnd + 1'b1;
    end

`ifdef DES_DECRYPT_EN
    // Direction is frozen for the whole operation at LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 dir <= 1'b0;
        else if (state == S_LOAD) dir <= dec;
    end
`else
    assign dir = 1'b0;
`endif

    assign rot_dir = dir;

    des_rot_lut u_lut (
        .idx (rnd[3:0]),
`ifdef DES_DECRYPT_EN
        .dir (dir),
`endif
        .rot (lut_rot)
    );

    // Output decode, from state only
    always_comb begin
        ld   = 1'b0;
        en   = 1'b0;
        fin  = 1'b0;
        ack  = 1'b0;
        rot  = 2'd0;
        busy = (state != S_IDLE);
        case (state)
            S_LOAD:  ld  = 1'b1;
            S_ROUND: begin
                en  = 1'b1;
                rot = lut_rot;
            end
            S_DONE:  fin = 1'b1;
            S_ACK:   ack = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_iter_ctrl
//   Self-checking bench for des_iter_ctrl. Behavioural model: rotation tables
//   as plain arrays and a transaction-level view of each operation (load,
//   16 rounds, finish, acknowledge). Honors DES_DECRYPT_EN.
// -----------------------------------------------------------------------------
module tb_des_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       ack, ld, en, fin, busy, rot_dir;
    logic [4:0] rnd;
    logic [1:0] rot;
`ifdef DES_DECRYPT_EN
    logic       dec;
`endif

    int nvec = 0;
    int nerr = 0;

    int enc_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int dec_tab [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    always #5 clk = ~clk;

    des_iter_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ack     (ack),
`ifdef DES_DECRYPT_EN
        .dec     (dec),
`endif
        .ld      (ld),
        .en      (en),
        .rnd     (rnd),
        .rot     (rot),
        .rot_dir (rot_dir),
        .fin     (fin),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".ld"},   32'(ld),   0);
        chk({tag, ".en"},   32'(en),   0);
        chk({tag, ".fin"},  32'(fin),  0);
        chk({tag, ".ack"},  32'(ack),  0);
        chk({tag, ".rot"},  32'(rot),  0);
    endtask

    // One full operation.
    //   d       : requested direction
    //   drop_at : round at which req is dropped early (-1 = never)
    //   hold    : cycles req stays high after ack rises
    task automatic run_op(input bit d, input int drop_at, input int hold);
        bit exp_dir;
        int rsum;
        int fins;
        bit dropped;
`ifdef DES_DECRYPT_EN
        exp_dir = d;
        dec     = d;
`else
        exp_dir = 1'b0;
`endif
        rsum    = 0;
        fins    = 0;
        dropped = 1'b0;
        req     = 1'b1;
        tick();
        chk("load.ld",   32'(ld),   1);
        chk("load.busy", 32'(busy), 1);
        chk("load.en",   32'(en),   0);
        chk("load.ack",  32'(ack),  0);
        tick();
        for (int r = 0; r < 16; r++) begin
            chk("rnd.en",      32'(en),      1);
            chk("rnd.idx",     32'(rnd),     32'(r));
            chk("rnd.rot",     32'(rot),     32'(exp_dir ? dec_tab[r] : enc_tab[r]));
            chk("rnd.rot_dir", 32'(rot_dir), 32'(exp_dir));
            chk("rnd.ld",      32'(ld),      0);
            fins += int'(fin);
            rsum += int'(rot);
            if (r == drop_at) begin
                req     = 1'b0;
                dropped = 1'b1;
            end
`ifdef DES_DECRYPT_EN
            dec = 1'($urandom);
`endif
            tick();
        end
        chk("rot.sum", 32'(rsum), exp_dir ? 27 : 28);
        chk("done.fin", 32'(fin), 1);
        chk("done.en",  32'(en),  0);
        chk("done.rot", 32'(rot), 0);
        chk("rnd.fin_early", 32'(fins), 0);
        tick();
        chk("ack.rise", 32'(ack), 1);
        chk("ack.fin",  32'(fin), 0);
        if (!dropped) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("ack.hold", 32'(ack), 1);
                chk("ack.ld",   32'(ld),  0);
            end
            req = 1'b0;
        end
        tick();
        chk("ack.fall", 32'(ack),  0);
        chk("idle.busy", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b0;
        req = 1'b0;
`ifdef DES_DECRYPT_EN
        dec = 1'b0;
`endif
        tick();
        tick();
        chk_idle("reset");
        chk("reset.rnd",     32'(rnd),     0);
        chk("reset.rot_dir", 32'(rot_dir), 0);
        rst = 1'b1;
        tick();
        chk_idle("post_reset");

        // Reset while in ROUND with rnd=7: outputs clear without a clock edge
        req = 1'b1;
        tick();
        tick();
        for (int r = 0; r < 7; r++) tick();
        chk("inflight.rnd", 32'(rnd), 7);
        chk("inflight.en",  32'(en),  1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("inflight_rst");
        chk("inflight_rst.rnd", 32'(rnd), 0);
        req = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle("after_rst");
        end

        // Directed: plain encrypt, long hold, immediate re-request
        run_op(1'b0, -1, 0);
        run_op(1'b0, -1, 10);
        run_op(1'b0, -1, 3);
        // Directed: decrypt request (encrypt table expected without the feature)
        run_op(1'b1, -1, 2);
        // Directed: early req drop at round 5 -> 1-cycle ack
        run_op(1'b0, 5, 0);

        // Randomized operations with idle gaps
        for (int n = 0; n < 24; n++) begin
            int gap;
            int drop;
            gap  = $urandom_range(0, 3);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            for (int g = 0; g < gap; g++) begin
                tick();
                chk_idle("gap");
            end
            run_op(1'($urandom), drop, $urandom_range(0, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
